// File: rtl/axis_master_burst_gen.sv
// AXI4-Stream master traffic generator.
// After an accepted start and a programmable idle delay it emits num_frames frames of
// NUMBER_OF_OUTPUT_WORDS beats (or runs continuously when num_frames is 0), honouring
// TREADY backpressure. A level stop finishes the current frame and then returns to idle.
module axis_master_burst_gen #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH   = 32,
  parameter int unsigned C_M_START_COUNT        = 32,
  parameter int unsigned NUMBER_OF_OUTPUT_WORDS = 8,
  parameter int unsigned C_DATA_BASE            = 0
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  input  logic                                start,
  input  logic [15:0]                         num_frames,
  input  logic                                stop,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned DW = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned WW = (NUMBER_OF_OUTPUT_WORDS > 1) ? $clog2(NUMBER_OF_OUTPUT_WORDS) : 1;
  localparam int unsigned CW = 32;

  localparam logic [WW-1:0] LAST_IDX   = WW'(NUMBER_OF_OUTPUT_WORDS - 1);
  localparam logic [DW-1:0] DATA_BASE  = DW'(C_DATA_BASE);
  localparam logic [DW-1:0] FRAME_STEP = DW'(NUMBER_OF_OUTPUT_WORDS);
  localparam logic          ONE_BEAT   = (LAST_IDX == WW'(0));

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   frames;
  logic [15:0]   frame_idx;
  logic [WW-1:0] word_idx;

  logic          handshake;
  logic          last_beat;
  logic          finish;
  logic [15:0]   frame_nxt;
  logic [WW-1:0] word_nxt;

  // Payload of a beat from its frame and word position, modulo the data width.
  function automatic logic [DW-1:0] beat_data(input logic [15:0] f, input logic [WW-1:0] w);
    return DATA_BASE + DW'(f) * FRAME_STEP + DW'(w);
  endfunction

  // Handshake and frame-boundary decode from registered state only (no TREADY-to-output path).
  assign handshake = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last_beat = (word_idx == LAST_IDX);
  assign frame_nxt = frame_idx + 16'd1;
  assign word_nxt  = word_idx + WW'(1);
  assign finish    = stop | ((frames != 16'd0) && (frame_nxt == frames));

  // Control FSM with registered stream and status outputs.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state         <= S_IDLE;
      cnt           <= '0;
      frames        <= '0;
      frame_idx     <= '0;
      word_idx      <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TSTRB  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WAIT;
            busy      <= 1'b1;
            cnt       <= CW'(C_M_START_COUNT);
            frames    <= num_frames;
            frame_idx <= '0;
            word_idx  <= '0;
          end
        end
        S_WAIT: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == CW'(0)) begin
            state         <= S_SEND;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= DATA_BASE;
            M_AXIS_TSTRB  <= '1;
            M_AXIS_TLAST  <= ONE_BEAT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_SEND: begin
          if (handshake) begin
            if (last_beat) begin
              word_idx  <= '0;
              frame_idx <= frame_nxt;
              if (finish) begin
                state         <= S_IDLE;
                M_AXIS_TVALID <= 1'b0;
                M_AXIS_TLAST  <= 1'b0;
                M_AXIS_TSTRB  <= '0;
                M_AXIS_TDATA  <= '0;
                busy          <= 1'b0;
                done          <= 1'b1;
              end else begin
                M_AXIS_TDATA <= beat_data(frame_nxt, WW'(0));
                M_AXIS_TLAST <= ONE_BEAT;
              end
            end else begin
              word_idx     <= word_nxt;
              M_AXIS_TDATA <= beat_data(frame_idx, word_nxt);
              M_AXIS_TLAST <= (word_nxt == LAST_IDX);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
